fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction-fetch stage: owns the fetch address, runs one imem transaction at a
// time and loads returned words into the IF/ID register for decode/prediction.
//
// state | meaning
// ISSUE | imem_req high, waiting for grant on next_pc
// WAIT  | granted, waiting for rvalid
// HOLD  | word parked in hold buffer while decode is stalled on a live IF/ID
// PRED  | IF/ID just loaded; sample predict_pc as the next fetch address
// DROP  | redirect pending; discard the outstanding response
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] correct_pc,
   input  logic [31:0] predict_pc,
   input  logic        id_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc,
   output logic [31:0] cur_pc,
   output logic [15:0] fetch_cnt,
   output logic [15:0] squash_cnt
);

   typedef enum logic [2:0] {ISSUE, WAIT, HOLD, PRED, DROP} state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic [31:0] next_pc_q, next_pc_d;
   logic [31:0] issued_pc_q, issued_pc_d;
   logic [31:0] hold_q, hold_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [15:0] fetch_cnt_q, fetch_cnt_d;
   logic [15:0] squash_cnt_q, squash_cnt_d;

   logic        gnt_ok;
   logic        load;
   logic [31:0] load_data;
   logic        drop;
   logic        kill;

   always_comb begin
      state_d     = state_q;
      next_pc_d   = next_pc_q;
      issued_pc_d = issued_pc_q;
      hold_d      = hold_q;
      load        = 1'b0;
      load_data   = imem_rdata;
      drop        = 1'b0;
      // req_q is low for the first cycle after reset, so a stray grant is ignored
      gnt_ok      = imem_gnt & req_q;

      case (state_q)
         ISSUE: begin
            if (gnt_ok) begin
               issued_pc_d = next_pc_q;
               state_d     = flush ? DROP : WAIT;
            end
         end
         WAIT: begin
            if (flush) begin
               if (imem_rvalid) begin
                  drop    = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = DROP;
               end
            end else if (imem_rvalid) begin
               if (!ifid_valid_q || !id_stall) begin
                  load    = 1'b1;
                  state_d = PRED;
               end else begin
                  hold_d  = imem_rdata;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (flush) begin
               drop    = 1'b1;
               state_d = ISSUE;
            end else if (!id_stall) begin
               load      = 1'b1;
               load_data = hold_q;
               state_d   = PRED;
            end
         end
         PRED: begin
            next_pc_d = predict_pc;
            state_d   = ISSUE;
         end
         DROP: begin
            if (imem_rvalid) begin
               drop    = 1'b1;
               state_d = ISSUE;
            end
         end
         default: state_d = ISSUE;
      endcase

      if (flush) next_pc_d = correct_pc;

      req_d = (state_d == ISSUE);
   end

   always_comb begin
      kill         = flush & ifid_valid_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      // flush beats stall; a load beats the consume of the previous entry
      if (flush) begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP_INSTR;
      end else if (load) begin
         ifid_valid_d = 1'b1;
         ifid_instr_d = load_data;
         ifid_pc_d    = issued_pc_q;
      end else if (ifid_valid_q && !id_stall) begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP_INSTR;
      end
      fetch_cnt_d  = fetch_cnt_q + {15'd0, load};
      squash_cnt_d = squash_cnt_q + {15'd0, drop} + {15'd0, kill};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ISSUE;
         req_q        <= 1'b0;
         next_pc_q    <= RESET_PC;
         issued_pc_q  <= RESET_PC;
         hold_q       <= 32'd0;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc_q    <= RESET_PC - 32'd4;
         fetch_cnt_q  <= 16'd0;
         squash_cnt_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         next_pc_q    <= next_pc_d;
         issued_pc_q  <= issued_pc_d;
         hold_q       <= hold_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         fetch_cnt_q  <= fetch_cnt_d;
         squash_cnt_q <= squash_cnt_d;
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = next_pc_q;
   assign ifid_valid = ifid_valid_q;
   assign ifid_instr = ifid_instr_q;
   assign ifid_pc    = ifid_pc_q;
   assign cur_pc     = ifid_pc_q + 32'd4;
   assign fetch_cnt  = fetch_cnt_q;
   assign squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Directed bench for fetch_unit: a scripted memory responder, a queue of expected
// IF/ID loads, and register-level checks around stalls, flushes and reset.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk, rst, flush, id_stall, imem_gnt, imem_rvalid;
   logic [31:0] correct_pc, predict_pc, imem_rdata;
   logic        imem_req, ifid_valid;
   logic [31:0] imem_addr, ifid_instr, ifid_pc, cur_pc;
   logic [15:0] fetch_cnt, squash_cnt;

   fetch_unit dut (
      .clk(clk), .rst(rst), .flush(flush), .correct_pc(correct_pc),
      .predict_pc(predict_pc), .id_stall(id_stall), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
      .ifid_pc(ifid_pc), .cur_pc(cur_pc), .fetch_cnt(fetch_cnt),
      .squash_cnt(squash_cnt)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          exp_fc = 0;
   int          exp_sq = 0;
   int          cyc = 0;
   int          g_cyc[3];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input logic [31:0] exp_addr, input string tag);
      for (int i = 0; i < 20 && imem_req !== 1'b1; i++) step();
      chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
      chk({tag, "_addr"}, imem_addr, exp_addr);
   endtask

   task automatic grant();
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
   endtask

   task automatic respond(input logic [31:0] addr, input logic keep);
      exp_t e;
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(addr);
      if (keep) begin
         e.pc    = addr;
         e.instr = word_of(addr);
         exp_q.push_back(e);
      end
      step();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hxxxx_xxxx;
   endtask

   task automatic check_load(input string tag);
      exp_t e;
      chk({tag, "_sb"}, exp_q.size(), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         exp_fc++;
         chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
         chk({tag, "_pc"}, ifid_pc, e.pc);
         chk({tag, "_instr"}, ifid_instr, e.instr);
         chk({tag, "_cur_pc"}, cur_pc, e.pc + 32'd4);
         chk({tag, "_fcnt"}, {16'd0, fetch_cnt}, exp_fc);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
      chk({tag, "_addr"}, imem_addr, 32'h0);
      chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd0);
      chk({tag, "_instr"}, ifid_instr, NOP);
      chk({tag, "_pc"}, ifid_pc, 32'hFFFF_FFFC);
      chk({tag, "_cur_pc"}, cur_pc, 32'h0);
      chk({tag, "_fcnt"}, {16'd0, fetch_cnt}, 32'd0);
      chk({tag, "_scnt"}, {16'd0, squash_cnt}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; id_stall = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
      correct_pc = 32'h0; predict_pc = 32'h0; imem_rdata = 32'h0;
      repeat (3) step();
      check_reset_vals("rst");
      rst = 1'b0;
      step();
      chk("first_req", {31'd0, imem_req}, 32'd1);

      // sequential fetch, L=1, 3-cycle cadence
      for (int k = 0; k < 3; k++) begin
         wait_req(32'(4 * k), "seq");
         g_cyc[k] = cyc;
         grant();
         respond(32'(4 * k), 1'b1);
         check_load("seq");
         predict_pc = 32'(4 * k + 4);
         step();
         chk("seq_consumed", {31'd0, ifid_valid}, 32'd0);
      end
      chk("cadence01", 32'(g_cyc[1] - g_cyc[0]), 32'd3);
      chk("cadence12", 32'(g_cyc[2] - g_cyc[1]), 32'd3);
      chk("fcnt3", {16'd0, fetch_cnt}, 32'd3);

      // predicted redirect
      wait_req(32'hC, "pr");
      grant();
      respond(32'hC, 1'b1);
      check_load("pr0");
      predict_pc = 32'h100;
      step();
      wait_req(32'h100, "pr_tgt");
      grant();
      respond(32'h100, 1'b1);
      check_load("pr1");

      // stall while response returns: hold buffer
      predict_pc = 32'h104;
      id_stall   = 1'b1;
      step();
      chk("st_held", {31'd0, ifid_valid}, 32'd1);
      wait_req(32'h104, "st");
      grant();
      respond(32'h104, 1'b1);
      chk("st_hold_req", {31'd0, imem_req}, 32'd0);
      chk("st_hold_pc", ifid_pc, 32'h100);
      step();
      chk("st_hold_req2", {31'd0, imem_req}, 32'd0);
      chk("st_hold_fcnt", {16'd0, fetch_cnt}, exp_fc);
      id_stall = 1'b0;
      step();
      check_load("st_rel");
      chk("st_scnt", {16'd0, squash_cnt}, exp_sq);

      // flush one cycle after grant, L=3
      predict_pc = 32'h108;
      step();
      wait_req(32'h108, "fl");
      grant();
      flush = 1'b1; correct_pc = 32'h200;
      step();
      flush = 1'b0;
      chk("fl_drop_instr", ifid_instr, NOP);
      step();
      respond(32'h108, 1'b0);
      exp_sq++;
      chk("fl_scnt", {16'd0, squash_cnt}, exp_sq);
      chk("fl_instr", ifid_instr, NOP);
      chk("fl_valid", {31'd0, ifid_valid}, 32'd0);
      wait_req(32'h200, "fl_tgt");
      grant();
      step();
      respond(32'h200, 1'b1);
      check_load("fl_tgt");

      // flush in PRED with stall
      predict_pc = 32'h204;
      step();
      wait_req(32'h204, "fp");
      grant();
      respond(32'h204, 1'b1);
      check_load("fp");
      flush = 1'b1; correct_pc = 32'h300; id_stall = 1'b1; predict_pc = 32'h999;
      step();
      flush = 1'b0; id_stall = 1'b0;
      exp_sq++;
      chk("fp_valid", {31'd0, ifid_valid}, 32'd0);
      chk("fp_instr", ifid_instr, NOP);
      chk("fp_scnt", {16'd0, squash_cnt}, exp_sq);
      wait_req(32'h300, "fp_tgt");

      // flush in ISSUE without grant
      flush = 1'b1; correct_pc = 32'h280;
      step();
      flush = 1'b0;
      chk("fi_scnt", {16'd0, squash_cnt}, exp_sq);
      wait_req(32'h280, "fi_tgt");
      grant();
      respond(32'h280, 1'b1);
      check_load("fi");

      // flush + rvalid in WAIT with live IF/ID: +2 squash
      id_stall = 1'b1; predict_pc = 32'h284;
      step();
      chk("dbl_held", {31'd0, ifid_valid}, 32'd1);
      wait_req(32'h284, "dbl");
      grant();
      flush = 1'b1; correct_pc = 32'h400;
      respond(32'h284, 1'b0);
      flush = 1'b0; id_stall = 1'b0;
      exp_sq += 2;
      chk("dbl_scnt", {16'd0, squash_cnt}, exp_sq);
      chk("dbl_valid", {31'd0, ifid_valid}, 32'd0);
      chk("dbl_fcnt", {16'd0, fetch_cnt}, exp_fc);
      wait_req(32'h400, "dbl_tgt");

      // reset while in WAIT, late rvalid ignored
      grant();
      #1 rst = 1'b1;
      #1;
      check_reset_vals("mrst");
      exp_fc = 0; exp_sq = 0;
      step();
      rst = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = word_of(32'h400);
      step();
      imem_rvalid = 1'b0;
      chk("mrst_valid", {31'd0, ifid_valid}, 32'd0);
      chk("mrst_fcnt", {16'd0, fetch_cnt}, 32'd0);
      wait_req(32'h0, "mrst");
      grant();
      respond(32'h0, 1'b1);
      check_load("mrst");
      chk("sb_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
